// File: rtl/twiddle_index_if.sv
// Stage-in / twiddle-index-out bundle between the FFT stage counter and the twiddle ROM.
interface twiddle_index_if;
  logic [2:0] stage_count_out;
  logic [2:0] index_val;

  modport master (output stage_count_out, input  index_val);
  modport slave  (input  stage_count_out, output index_val);
endinterface

// File: rtl/twiddle_index.sv
// Twiddle index generator for an 8-point radix-2 DIT FFT: k = (c mod 2^s) * 2^(2-s),
// with the butterfly count c tracked per stage and the result registered (1-cycle latency).
module twiddle_index (
  input  logic           clk,
  input  logic           nrst,
  twiddle_index_if.slave tw
);

  logic [2:0] prev_stage;
  logic [1:0] bfly;
  logic [2:0] index_q;

  logic       invalid;
  logic [1:0] c;
  logic [2:0] index_nxt;
  logic [1:0] bfly_nxt;

  // A new or invalid stage restarts the butterfly count on this same edge.
  always_comb begin
    invalid   = (tw.stage_count_out > 3'd2);
    c         = (invalid || (tw.stage_count_out != prev_stage)) ? 2'd0 : bfly;
    bfly_nxt  = invalid ? 2'd0 : c + 2'd1;
    index_nxt = 3'd0;
    case (tw.stage_count_out)
      3'd1:    index_nxt = {1'b0, c[0], 1'b0};
      3'd2:    index_nxt = {1'b0, c};
      default: index_nxt = 3'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      prev_stage <= 3'd0;
      bfly       <= 2'd0;
      index_q    <= 3'd0;
    end else begin
      prev_stage <= tw.stage_count_out;
      bfly       <= bfly_nxt;
      index_q    <= index_nxt;
    end
  end

  assign tw.index_val = index_q;

endmodule

// File: tb/tb_twiddle_index.sv
// Directed bench for twiddle_index: each step drives stage/reset, clocks once, checks index_val.
module tb_twiddle_index;

  logic tb_clk = 1'b0;
  logic nrst   = 1'b1;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  twiddle_index_if tw_if ();

  twiddle_index dut (
    .clk  (tb_clk),
    .nrst (nrst),
    .tw   (tw_if.slave)
  );

  always #5 tb_clk = ~tb_clk;

  // Inputs change on the falling edge; the output is sampled 1 time unit after the rising edge.
  task automatic step(input logic rst, input logic [2:0] stage,
                      input logic [2:0] exp, input string tag);
    @(negedge tb_clk);
    nrst = rst;
    tw_if.stage_count_out = stage;
    @(posedge tb_clk);
    #1;
    total_cnt++;
    assert (tw_if.index_val === exp) pass_cnt++;
    else $error("FAIL %s: index_val=%0d expected=%0d", tag, tw_if.index_val, exp);
  endtask

  initial begin
    tw_if.stage_count_out = 3'd3;

    // 1: reset, then stage 0 held
    step(1'b1, 3'd3, 3'd0, "reset0");
    step(1'b1, 3'd6, 3'd0, "reset1");
    for (int i = 0; i < 8; i++) step(1'b0, 3'd0, 3'd0, "stage0_hold");

    // 2: stage 0 -> 1
    step(1'b0, 3'd1, 3'd0, "s1_first");
    step(1'b0, 3'd1, 3'd2, "s1_c1");
    step(1'b0, 3'd1, 3'd0, "s1_c2");
    step(1'b0, 3'd1, 3'd2, "s1_c3");
    step(1'b0, 3'd1, 3'd0, "s1_wrap");
    step(1'b0, 3'd1, 3'd2, "s1_c1b");

    // 3: stage 1 -> 2 with wrap
    step(1'b0, 3'd2, 3'd0, "s2_first");
    step(1'b0, 3'd2, 3'd1, "s2_c1");
    step(1'b0, 3'd2, 3'd2, "s2_c2");
    step(1'b0, 3'd2, 3'd3, "s2_c3");
    step(1'b0, 3'd2, 3'd0, "s2_wrap");
    step(1'b0, 3'd2, 3'd1, "s2_c1b");
    step(1'b0, 3'd2, 3'd2, "s2_c2b");

    // 4: mid-sequence switch 2 -> 1 -> 2
    step(1'b0, 3'd1, 3'd0, "sw_to_s1");
    step(1'b0, 3'd1, 3'd2, "sw_s1_c1");
    step(1'b0, 3'd2, 3'd0, "sw_back_s2");

    // 5: invalid stage, then back to 2
    step(1'b0, 3'd5, 3'd0, "inv0");
    step(1'b0, 3'd5, 3'd0, "inv1");
    step(1'b0, 3'd5, 3'd0, "inv2");
    step(1'b0, 3'd2, 3'd0, "post_inv_c0");
    step(1'b0, 3'd2, 3'd1, "post_inv_c1");
    step(1'b0, 3'd2, 3'd2, "post_inv_c2");

    // 6: reset mid-sequence with stage 2 still driven
    step(1'b1, 3'd2, 3'd0, "mid_reset");
    step(1'b0, 3'd2, 3'd0, "rr_c0");
    step(1'b0, 3'd2, 3'd1, "rr_c1");
    step(1'b0, 3'd2, 3'd2, "rr_c2");
    step(1'b0, 3'd2, 3'd3, "rr_c3");
    step(1'b0, 3'd2, 3'd0, "rr_wrap");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/twiddle_index.md
Name: twiddle_index

Overview:
- Twiddle-factor index generator for the 8-point radix-2 decimation-in-time FFT datapath.
- Takes the current stage number from the stage counter and tracks the butterfly position within that stage internally.
- Outputs a registered 3-bit index k into the W8^k twiddle ROM, with one cycle of latency.
- Sits between the FFT control stage counter and the twiddle coefficient ROM.

Parameters:
- None. The block is fixed at N=8 (3 stages, 4 butterflies per stage, 3-bit index).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- nrst  input  1  synchronous, active-high reset. The name follows the codebase convention; the polarity is high-active.
- stage_count_out  input  3  current FFT stage from the stage counter. Values 0..2 are valid; 3..7 are invalid.
- index_val  output  3  registered twiddle index k (0..3 used; bit 2 always 0).

Behaviour:
- Registers: prev_stage[2:0], bfly[1:0], index_val[2:0]. All are updated only on the rising edge of clk.
- Reset: if nrst==1 at a rising edge, then prev_stage<=0, bfly<=0, index_val<=0. Reset has priority over everything else.
- Reset mid-operation: outputs and counters return to 0 on the next edge. Counting restarts at butterfly 0 on the first edge after nrst returns to 0.
- Normal edge (nrst==0):
  - Effective count c = 0 if (stage_count_out != prev_stage) or (stage_count_out > 2); otherwise c = bfly.
  - index_val <= tw(stage_count_out, c).
  - bfly <= 0 if stage_count_out > 2; otherwise (c+1) mod 4, wrapping 3 -> 0.
  - prev_stage <= stage_count_out.
- Twiddle mapping tw(s,c) = (c mod 2^s) * 2^(2-s):
  - s=0: 0 for all c.
  - s=1: 0,2,0,2 for c=0,1,2,3.
  - s=2: 0,1,2,3 for c=0,1,2,3.
  - s>=3: 0.
- Stage change: a new stage value always restarts its butterfly sequence at c=0 on the same edge. The first output for a new stage is therefore tw(s,0)=0.
- Stage held: the sequence repeats every 4 cycles. Wrap-around is seamless, with no idle cycle.
- Latency: index_val reflects the stage_count_out sampled at the previous rising edge. There is no combinational path from input to output.
- Unknown input before the first drive: there is no special handling. Once a valid stage is applied, behaviour follows the rules above.
- index_val[2] is always 0.

Test Plan:
1. Assert nrst for 2 edges with any stage value -> index_val==0 one edge later. Deassert nrst, drive stage 0 and hold it for 8 edges -> index_val==0 on every edge.
2. After reset, change stage 0 -> 1. First edge after the change -> index_val==0. Hold stage 1 -> next outputs 2,0,2,0,2 (sequence 0,2,0,2 repeating).
3. Change stage 1 -> 2 -> index_val sequence 0,1,2,3,0,1 on successive edges, showing the wrap 3 -> 0.
4. While in stage 2 with index_val==2, change to stage 1 -> next edge index_val==0, then 2. Change back to stage 2 -> next edge index_val==0.
5. Drive stage 5 for 3 edges -> index_val==0 each edge. Return to stage 2 -> sequence 0,1,2,...
6. During stage 2 at index 2, assert nrst for 1 edge -> index_val==0. Deassert with stage 2 still driven -> sequence 1,2,3,0. Reset forces prev_stage to 0, so the first post-reset edge detects a stage change and outputs 0, i.e. the full sequence is 0,1,2,3,0.
